// File: rtl/gray_count_ctrl.sv
// Binary/gray up-down counter advanced by a free-running prescaled RUN mode or single STEP pulses.
// Latency: bin/tick/wrap register on the advance edge; gray is combinational from bin.
// Backpressure: none; step is dropped outside IDLE, clear and rst override everything.
module gray_count_ctrl #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic             clear,
    input  logic             up,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             tick,
    output logic             wrap,
    output logic [1:0]       state
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [PW-1:0]    presc_q;
    logic [PW-1:0]    presc_d;
    logic             adv;
    logic             wrap_d;
    logic [WIDTH-1:0] bin_d;

    always_comb begin
        state_d = IDLE;
        presc_d = '0;
        adv     = 1'b0;
        case (state_q)
            IDLE: begin
                if (run)
                    state_d = RUN;
                else if (step)
                    state_d = STEP;
                else
                    state_d = IDLE;
            end
            RUN: begin
                // Dropping run abandons the partial prescale count without advancing.
                if (run) begin
                    state_d = RUN;
                    if (presc_q == PLAST)
                        adv = 1'b1;
                    else
                        presc_d = presc_q + PW'(1);
                end
            end
            STEP: begin
                adv     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bin_d  = up ? (bin + WIDTH'(1)) : (bin - WIDTH'(1));
    assign wrap_d = adv && (up ? (&bin) : (bin == '0));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q <= IDLE;
            presc_q <= '0;
            bin     <= '0;
            tick    <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tick    <= adv;
            wrap    <= wrap_d;
            if (adv)
                bin <= bin_d;
        end
    end

    assign gray  = bin ^ (bin >> 1);
    assign state = state_q;

endmodule

// File: tb/tb_gray_count_ctrl.sv
// Directed bench for gray_count_ctrl: scoreboarded PRESCALE=4 sequences plus a PRESCALE=1 full sweep.
module tb_gray_count_ctrl;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STEP = 2'd2;

    logic       clk;
    logic       rst, run, step, clear, up;
    logic [7:0] bin, gray, bin1, gray1;
    logic       tick, wrap, tick1, wrap1;
    logic [1:0] state, state1;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [7:0] bin;
        logic [7:0] gray;
        logic       tick;
        logic       wrap;
        logic [1:0] st;
    } exp_t;

    exp_t  sb[$];
    string tq[$];

    gray_count_ctrl #(.WIDTH(8), .PRESCALE(4)) u_dut (
        .clk(clk), .rst(rst), .run(run), .step(step), .clear(clear), .up(up),
        .bin(bin), .gray(gray), .tick(tick), .wrap(wrap), .state(state)
    );

    gray_count_ctrl #(.WIDTH(8), .PRESCALE(1)) u_dut1 (
        .clk(clk), .rst(rst), .run(run), .step(step), .clear(clear), .up(up),
        .bin(bin1), .gray(gray1), .tick(tick1), .wrap(wrap1), .state(state1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic expect_next(input string tag, input logic [7:0] b, input logic [7:0] g,
                               input logic t, input logic w, input logic [1:0] s);
        exp_t e;
        e.bin  = b;
        e.gray = g;
        e.tick = t;
        e.wrap = w;
        e.st   = s;
        sb.push_back(e);
        tq.push_back(tag);
    endtask

    task automatic clk1();
        exp_t  e;
        string tag;
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            e   = sb.pop_front();
            tag = tq.pop_front();
            chk({tag, ".bin"},   bin,   e.bin);
            chk({tag, ".gray"},  gray,  e.gray);
            chk({tag, ".tick"},  {7'd0, tick}, {7'd0, e.tick});
            chk({tag, ".wrap"},  {7'd0, wrap}, {7'd0, e.wrap});
            chk({tag, ".state"}, {6'd0, state}, {6'd0, e.st});
        end
    endtask

    initial begin
        logic [7:0]   kb;
        logic [7:0]   mb;
        logic [7:0]   pg;
        logic [255:0] seen;
        int           dups;
        int           wraps;

        rst = 1'b1; run = 1'b0; step = 1'b0; clear = 1'b0; up = 1'b1;
        expect_next("reset", 8'h00, 8'h00, 1'b0, 1'b0, S_IDLE);
        clk1();
        rst = 1'b0;

        // Free run with PRESCALE=4: enter RUN on edge 1, advance on edges 5 and 9.
        run = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            if (e == 5)
                expect_next("run_e5", 8'h01, 8'h01, 1'b1, 1'b0, S_RUN);
            else if (e == 9)
                expect_next("run_e9", 8'h02, 8'h03, 1'b1, 1'b0, S_RUN);
            else if (e < 5)
                expect_next("run_gap_a", 8'h00, 8'h00, 1'b0, 1'b0, S_RUN);
            else
                expect_next("run_gap_b", 8'h01, 8'h01, 1'b0, 1'b0, S_RUN);
            clk1();
        end
        run = 1'b0;
        expect_next("run_stop", 8'h02, 8'h03, 1'b0, 1'b0, S_IDLE);
        clk1();
        clear = 1'b1;
        expect_next("clear", 8'h00, 8'h00, 1'b0, 1'b0, S_IDLE);
        clk1();
        clear = 1'b0;

        // Single step; step held into the STEP cycle must not queue a second advance.
        step = 1'b1;
        expect_next("step_enter", 8'h00, 8'h00, 1'b0, 1'b0, S_STEP);
        clk1();
        expect_next("step_adv", 8'h01, 8'h01, 1'b1, 1'b0, S_IDLE);
        clk1();
        step = 1'b0;
        expect_next("step_noqueue", 8'h01, 8'h01, 1'b0, 1'b0, S_IDLE);
        clk1();

        // Count down through zero, then back up through all-ones.
        up = 1'b0; step = 1'b1;
        expect_next("dn_enter", 8'h01, 8'h01, 1'b0, 1'b0, S_STEP);
        clk1();
        step = 1'b0;
        expect_next("dn_to0", 8'h00, 8'h00, 1'b1, 1'b0, S_IDLE);
        clk1();
        step = 1'b1;
        expect_next("wdn_enter", 8'h00, 8'h00, 1'b0, 1'b0, S_STEP);
        clk1();
        step = 1'b0;
        expect_next("wrap_dn", 8'hFF, 8'h80, 1'b1, 1'b1, S_IDLE);
        clk1();
        up = 1'b1; step = 1'b1;
        expect_next("wup_enter", 8'hFF, 8'h80, 1'b0, 1'b0, S_STEP);
        clk1();
        step = 1'b0;
        expect_next("wrap_up", 8'h00, 8'h00, 1'b1, 1'b1, S_IDLE);
        clk1();
        expect_next("wrap_low", 8'h00, 8'h00, 1'b0, 1'b0, S_IDLE);
        clk1();

        // Step up to 5, then clear beats run and step together.
        for (int k = 1; k <= 5; k++) begin
            kb = 8'(k - 1);
            step = 1'b1;
            expect_next("build_enter", kb, kb ^ (kb >> 1), 1'b0, 1'b0, S_STEP);
            clk1();
            kb = 8'(k);
            step = 1'b0;
            expect_next("build_adv", kb, kb ^ (kb >> 1), 1'b1, 1'b0, S_IDLE);
            clk1();
        end
        clear = 1'b1; run = 1'b1; step = 1'b1;
        expect_next("prio_clear", 8'h00, 8'h00, 1'b0, 1'b0, S_IDLE);
        clk1();
        clear = 1'b0; run = 1'b0; step = 1'b0;
        step = 1'b1;
        expect_next("pre_rst_enter", 8'h00, 8'h00, 1'b0, 1'b0, S_STEP);
        clk1();
        step = 1'b0;
        expect_next("pre_rst_adv", 8'h01, 8'h01, 1'b1, 1'b0, S_IDLE);
        clk1();
        rst = 1'b1; clear = 1'b1; run = 1'b1; step = 1'b1;
        expect_next("rst_clear", 8'h00, 8'h00, 1'b0, 1'b0, S_IDLE);
        clk1();
        rst = 1'b0; clear = 1'b0; run = 1'b0; step = 1'b0;

        // Run dropped mid-prescale, then re-entered: full 4 cycles to first advance.
        run = 1'b1;
        expect_next("drop_e1", 8'h00, 8'h00, 1'b0, 1'b0, S_RUN);
        clk1();
        expect_next("drop_e2", 8'h00, 8'h00, 1'b0, 1'b0, S_RUN);
        clk1();
        run = 1'b0;
        expect_next("drop_idle", 8'h00, 8'h00, 1'b0, 1'b0, S_IDLE);
        clk1();
        run = 1'b1;
        expect_next("rerun", 8'h00, 8'h00, 1'b0, 1'b0, S_RUN);
        clk1();
        for (int i = 0; i < 3; i++) begin
            expect_next("rerun_gap", 8'h00, 8'h00, 1'b0, 1'b0, S_RUN);
            clk1();
        end
        expect_next("rerun_adv", 8'h01, 8'h01, 1'b1, 1'b0, S_RUN);
        clk1();
        for (int i = 0; i < 3; i++) begin
            expect_next("due_gap", 8'h01, 8'h01, 1'b0, 1'b0, S_RUN);
            clk1();
        end
        clear = 1'b1;
        expect_next("clear_due", 8'h00, 8'h00, 1'b0, 1'b0, S_IDLE);
        clk1();
        clear = 1'b0; run = 1'b0;
        expect_next("after_clear", 8'h00, 8'h00, 1'b0, 1'b0, S_IDLE);
        clk1();

        // PRESCALE=1 sweep over all 256 codes.
        rst = 1'b1;
        clk1();
        rst = 1'b0; run = 1'b1; up = 1'b1;
        clk1();
        chk("sweep_enter.state", {6'd0, state1}, {6'd0, S_RUN});
        chk("sweep_enter.bin", bin1, 8'h00);
        mb    = 8'h00;
        pg    = gray1;
        seen  = '0;
        seen[gray1] = 1'b1;
        dups  = 0;
        wraps = 0;
        for (int i = 0; i < 256; i++) begin
            clk1();
            mb = mb + 8'h01;
            chk("sweep.bin", bin1, mb);
            chk("sweep.gray", gray1, mb ^ (mb >> 1));
            chk("sweep.tick", {7'd0, tick1}, 8'h01);
            chk("sweep.onebit", 8'($countones(gray1 ^ pg)), 8'h01);
            chk("sweep.wrap", {7'd0, wrap1}, (i == 255) ? 8'h01 : 8'h00);
            if (i != 255) begin
                if (seen[gray1])
                    dups++;
                seen[gray1] = 1'b1;
            end
            if (wrap1)
                wraps++;
            pg = gray1;
        end
        run = 1'b0;
        chk("sweep.all_codes", {7'd0, &seen}, 8'h01);
        chk("sweep.dups", 8'(dups), 8'h00);
        chk("sweep.wrap_count", 8'(wraps), 8'h01);
        chk("sb_drained", 8'(sb.size()), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gray_count_ctrl.md
GRAY_COUNT_CTRL -- requirements
Module: gray_count_ctrl

Interface
REQ-001 SHALL provide parameter WIDTH, default 8: count width in bits, minimum 2.
REQ-002 SHALL provide parameter PRESCALE, default 4: number of clk cycles per advance in RUN, minimum 1.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL provide port clk, input, 1 bit: rising-edge clock.
REQ-005 SHALL provide port rst, input, 1 bit: synchronous reset, active-high.
REQ-006 SHALL provide port run, input, 1 bit: level; while high, advance every PRESCALE cycles.
REQ-007 SHALL provide port step, input, 1 bit: single-cycle pulse; requests one advance.
REQ-008 SHALL provide port clear, input, 1 bit: single-cycle pulse; zero the count.
REQ-009 SHALL provide port up, input, 1 bit: direction, 1 = increment, 0 = decrement; sampled on the advance cycle.
REQ-010 SHALL provide port bin, output, WIDTH bits: registered binary count.
REQ-011 SHALL provide port gray, output, WIDTH bits: gray code of bin.
REQ-012 SHALL provide port tick, output, 1 bit: registered pulse, high for the one cycle in which a new count is presented.
REQ-013 SHALL provide port wrap, output, 1 bit: registered pulse, coincident with tick when the advance wrapped.
REQ-014 SHALL provide port state, output, 2 bits: FSM state, IDLE=0, RUN=1, STEP=2.

Function
REQ-015 SHALL compute gray = bin XOR (bin >> 1) combinationally from the bin register, with no extra latency.
REQ-016 SHALL implement an FSM with states IDLE, RUN and STEP; encoding 3 SHALL be unreachable and SHALL return to IDLE on the next clk.
REQ-017 SHALL, in IDLE with run=1, move to RUN and load the prescaler with 0; run SHALL take priority over step.
REQ-018 SHALL, in IDLE with run=0 and step=1, move to STEP.
REQ-019 SHALL, in STEP, perform exactly one advance on that clk edge and return to IDLE regardless of run or step.
REQ-020 SHALL, in RUN, increment the prescaler every cycle; when the prescaler equals PRESCALE-1 it SHALL advance and reload 0.
REQ-021 SHALL, in RUN with run=0, return to IDLE, clear the prescaler and not advance that cycle.
REQ-022 SHALL ignore step in RUN and in STEP; steps SHALL NOT be queued.
REQ-023 SHALL define an advance as: bin <= bin+1 if up=1, else bin-1, modulo 2^WIDTH.
REQ-024 SHALL register tick=1 on the same edge as every advance, and tick=0 otherwise.
REQ-025 SHALL register wrap=1 on the same edge as an advance from all-ones to 0 (up=1) or from 0 to all-ones (up=0), and wrap=0 otherwise.
REQ-026 SHALL give clear priority over run, step and any due advance: bin <= 0, prescaler <= 0, state <= IDLE, tick <= 0, wrap <= 0.
REQ-027 SHALL, with PRESCALE=1, advance on every RUN cycle.
REQ-028 SHALL make consecutive gray values differ in exactly one bit across every advance, including wrap.

Reset
REQ-029 SHALL, when rst=1 at a clk edge, set bin=0, gray=0, tick=0, wrap=0, state=IDLE and prescaler=0.
REQ-030 SHALL give rst priority over clear, run and step.
REQ-031 SHALL, on rst mid-RUN or mid-STEP, discard any pending advance.
REQ-032 SHALL require no reset-release sequencing: the first edge with rst=0 obeys REQ-017 to REQ-026.

Verification
REQ-033 SHALL verify RUN timing: WIDTH=8, PRESCALE=4, reset, then run=1 held -> state=RUN after 1 edge; bin=1, gray=01h, tick=1 on edge 5; bin=2, gray=03h on edge 9; tick low in between.
REQ-034 SHALL verify single step: step pulse in IDLE with up=1 from bin=0 -> state=STEP, then bin=1, tick=1, state=IDLE; a second step pulse issued while in STEP is ignored.
REQ-035 SHALL verify wrap in both directions: bin=0FFh with up=1 and one step -> bin=00h, gray=00h, wrap=1; bin=00h with up=0 and one step -> bin=0FFh, gray=80h, wrap=1.
REQ-036 SHALL verify priority: clear, run and step all high in IDLE with bin=5 -> bin=0, state=IDLE, tick=0; rst and clear together -> reset values.
REQ-037 SHALL verify run dropped mid-prescale: run low 2 cycles after entering RUN -> IDLE, no tick, bin unchanged; run high again -> first advance a full 4 cycles after RUN is re-entered.
REQ-038 SHALL run a 256-advance free sweep with PRESCALE=1: every gray transition flips exactly 1 bit, all 256 codes appear once, and wrap pulses exactly once.
